// File: rtl/roberto_pkg.sv
// Shared ASCII constants, parser state encoding and character classifiers
// for the robot's serial command interpreter.
package roberto_pkg;

    localparam logic [6:0] ASC_ZERO = 7'h30;
    localparam logic [6:0] ASC_UM   = 7'h31;
    localparam logic [6:0] ASC_TRES = 7'h33;
    localparam logic [6:0] ASC_SETE = 7'h37;
    localparam logic [6:0] ASC_FIM  = 7'h23;

    // Encoding doubles as the db_estado code shown on the hexa7seg display
    typedef enum logic [3:0] {
        ESPERA_ID  = 4'd0,
        ESPERA_POS = 4'd1,
        ESPERA_FIM = 4'd2
    } estado_t;

    function automatic logic eh_id(input logic [6:0] c);
        return (c >= ASC_UM) && (c <= ASC_TRES);
    endfunction

    function automatic logic eh_pos(input logic [6:0] c);
        return (c >= ASC_ZERO) && (c <= ASC_SETE);
    endfunction

endpackage

// File: rtl/gerador_pwm.sv
// One servo PWM channel: shadow width reloaded only at the shared counter wrap,
// registered output high while the counter is below the active width.
module gerador_pwm #(
    parameter int unsigned PERIODO     = 1_000_000,
    parameter int unsigned LARGURA_MIN = 50_000,
    parameter int unsigned PASSO       = 7_143,
    parameter int unsigned W           = $clog2(PERIODO)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] i_contador,
    input  logic         i_virada,
    input  logic [2:0]   i_posicao,
    output logic         o_pwm
);

    logic [W-1:0] r_largura_ativa;
    logic         r_pwm;
    logic [W-1:0] w_largura_nova;

    assign w_largura_nova = W'(LARGURA_MIN + PASSO * 32'(i_posicao));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_largura_ativa <= W'(LARGURA_MIN);
            r_pwm           <= 1'b0;
        end else begin
            // Loading on the wrap edge means the compare at counter=0 already sees the new width
            if (i_virada)
                r_largura_ativa <= w_largura_nova;
            r_pwm <= (i_contador < r_largura_ativa);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/interpretador_servos.sv
// Serial command parser ("<id><pos>#") driving three position registers and
// three 50 Hz servo PWM channels from a shared free-running counter.
module interpretador_servos
    import roberto_pkg::*;
#(
    parameter int unsigned PERIODO     = 1_000_000,
    parameter int unsigned LARGURA_MIN = 50_000,
    parameter int unsigned PASSO       = 7_143
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] dado_recebido,
    input  logic       pronto_recepcao,
    output logic       PMW1,
    output logic       PMW2,
    output logic       PMW3,
    output logic [2:0] posicao1,
    output logic [2:0] posicao2,
    output logic [2:0] posicao3,
    output logic       comando_valido,
    output logic       erro_comando,
    output logic [3:0] db_estado
);

    localparam int unsigned W = $clog2(PERIODO);

    estado_t      r_estado, w_prox_estado;
    logic [1:0]   r_id_pendente;
    logic [2:0]   r_pos_pendente;
    logic [2:0]   r_posicao1, r_posicao2, r_posicao3;
    logic         r_valido, r_erro;
    logic         w_valido, w_erro, w_latch_id, w_latch_pos;
    logic [W-1:0] r_contador;
    logic         w_virada;

    always_comb begin
        w_prox_estado = r_estado;
        w_valido      = 1'b0;
        w_erro        = 1'b0;
        w_latch_id    = 1'b0;
        w_latch_pos   = 1'b0;
        if (pronto_recepcao) begin
            case (r_estado)
                ESPERA_ID: begin
                    if (eh_id(dado_recebido)) begin
                        w_latch_id    = 1'b1;
                        w_prox_estado = ESPERA_POS;
                    end else begin
                        w_erro = 1'b1;
                    end
                end
                ESPERA_POS: begin
                    if (eh_pos(dado_recebido)) begin
                        w_latch_pos   = 1'b1;
                        w_prox_estado = ESPERA_FIM;
                    end else begin
                        w_erro        = 1'b1;
                        w_prox_estado = ESPERA_ID;
                    end
                end
                ESPERA_FIM: begin
                    if (dado_recebido == ASC_FIM)
                        w_valido = 1'b1;
                    else
                        w_erro   = 1'b1;
                    w_prox_estado = ESPERA_ID;
                end
                default: w_prox_estado = ESPERA_ID;
            endcase
        end
    end

    // '1'..'3' and '0'..'7' carry their value in the low ASCII bits (0x30 base)
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado       <= ESPERA_ID;
            r_id_pendente  <= '0;
            r_pos_pendente <= '0;
            r_posicao1     <= '0;
            r_posicao2     <= '0;
            r_posicao3     <= '0;
            r_valido       <= 1'b0;
            r_erro         <= 1'b0;
        end else begin
            r_estado <= w_prox_estado;
            r_valido <= w_valido;
            r_erro   <= w_erro;
            if (w_latch_id)
                r_id_pendente <= dado_recebido[1:0];
            if (w_latch_pos)
                r_pos_pendente <= dado_recebido[2:0];
            if (w_valido) begin
                case (r_id_pendente)
                    2'd1:    r_posicao1 <= r_pos_pendente;
                    2'd2:    r_posicao2 <= r_pos_pendente;
                    2'd3:    r_posicao3 <= r_pos_pendente;
                    default: ;
                endcase
            end
        end
    end

    assign w_virada = (r_contador == W'(PERIODO - 1));

    always_ff @(posedge clock) begin
        if (!reset)
            r_contador <= '0;
        else if (w_virada)
            r_contador <= '0;
        else
            r_contador <= r_contador + 1'b1;
    end

    gerador_pwm #(.PERIODO(PERIODO), .LARGURA_MIN(LARGURA_MIN), .PASSO(PASSO), .W(W)) u_pwm1 (
        .clock(clock), .reset(reset), .i_contador(r_contador), .i_virada(w_virada),
        .i_posicao(r_posicao1), .o_pwm(PMW1)
    );

    gerador_pwm #(.PERIODO(PERIODO), .LARGURA_MIN(LARGURA_MIN), .PASSO(PASSO), .W(W)) u_pwm2 (
        .clock(clock), .reset(reset), .i_contador(r_contador), .i_virada(w_virada),
        .i_posicao(r_posicao2), .o_pwm(PMW2)
    );

    gerador_pwm #(.PERIODO(PERIODO), .LARGURA_MIN(LARGURA_MIN), .PASSO(PASSO), .W(W)) u_pwm3 (
        .clock(clock), .reset(reset), .i_contador(r_contador), .i_virada(w_virada),
        .i_posicao(r_posicao3), .o_pwm(PMW3)
    );

    assign posicao1       = r_posicao1;
    assign posicao2       = r_posicao2;
    assign posicao3       = r_posicao3;
    assign comando_valido = r_valido;
    assign erro_comando   = r_erro;
    assign db_estado      = r_estado;

endmodule

// File: tb/tb_interpretador_servos.sv
// Directed bench for interpretador_servos with PERIODO=100, LARGURA_MIN=10, PASSO=2.
module tb_interpretador_servos;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] dado_recebido = '0;
    logic       pronto_recepcao = 1'b0;
    logic       PMW1, PMW2, PMW3;
    logic [2:0] posicao1, posicao2, posicao3;
    logic       comando_valido, erro_comando;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;   // edges since reset release; DUT counter equals n mod 100
    int h1, h2, h3;

    interpretador_servos #(.PERIODO(100), .LARGURA_MIN(10), .PASSO(2)) dut (
        .clock(clock), .reset(reset), .dado_recebido(dado_recebido),
        .pronto_recepcao(pronto_recepcao), .PMW1(PMW1), .PMW2(PMW2), .PMW3(PMW3),
        .posicao1(posicao1), .posicao2(posicao2), .posicao3(posicao3),
        .comando_valido(comando_valido), .erro_comando(erro_comando), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) n <= reset ? n + 1 : 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_n(input int target);
        int k = 0;
        while (n < target && k < 5000) begin
            @(negedge clock);
            k++;
        end
        if (k == 5000) chk("timeout", n, target);
    endtask

    // Counts high cycles per channel over the 100 samples taken at negedges n=start..start+99
    task automatic medir(input int start, output int a, output int b, output int c);
        a = 0; b = 0; c = 0;
        wait_n(start);
        for (int i = 0; i < 100; i++) begin
            a += int'(PMW1); b += int'(PMW2); c += int'(PMW3);
            @(negedge clock);
        end
    endtask

    // Called at a negedge; presents one character for the next edge and checks the pulses after it
    task automatic enviar(input logic [6:0] c, input int exp_ok, input int exp_err, input int exp_est);
        dado_recebido   = c;
        pronto_recepcao = 1'b1;
        @(negedge clock);
        pronto_recepcao = 1'b0;
        dado_recebido   = 7'h55;
        chk("valido", int'(comando_valido), exp_ok);
        chk("erro", int'(erro_comando), exp_err);
        chk("estado", int'(db_estado), exp_est);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_pos1", int'(posicao1), 0);
        chk("rst_pos2", int'(posicao2), 0);
        chk("rst_pos3", int'(posicao3), 0);
        chk("rst_pwm", int'({PMW1, PMW2, PMW3}), 0);
        chk("rst_pulsos", int'({comando_valido, erro_comando}), 0);
        reset = 1'b1;

        // Idle after release: 10 high per period
        medir(1, h1, h2, h3);
        chk("idle_h1", h1, 10); chk("idle_h2", h2, 10); chk("idle_h3", h3, 10);

        // "25#" mid-period: current period unchanged, next period 20 high on PMW2
        fork
            begin
                medir(101, h1, h2, h3);
                chk("p25_atual_h2", h2, 10);
            end
            begin
                wait_n(130);
                enviar("2", 0, 0, 1);
                enviar("5", 0, 0, 2);
                enviar("#", 1, 0, 0);
                @(negedge clock);
                chk("p25_pulso_unico", int'(comando_valido), 0);
                chk("p25_pos1", int'(posicao1), 0);
                chk("p25_pos2", int'(posicao2), 5);
                chk("p25_pos3", int'(posicao3), 0);
            end
        join
        medir(201, h1, h2, h3);
        chk("p25_h1", h1, 10); chk("p25_h2", h2, 20); chk("p25_h3", h3, 10);

        // "3X#" then "17#"
        wait_n(310);
        enviar("3", 0, 0, 1);
        enviar("X", 0, 1, 0);
        enviar("#", 0, 1, 0);
        enviar("1", 0, 0, 1);
        enviar("7", 0, 0, 2);
        enviar("#", 1, 0, 0);
        chk("p17_pos1", int'(posicao1), 7);
        chk("p17_pos2", int'(posicao2), 5);
        chk("p17_pos3", int'(posicao3), 0);
        medir(401, h1, h2, h3);
        chk("p17_h1", h1, 24); chk("p17_h2", h2, 20); chk("p17_h3", h3, 10);

        // "48#": every character rejected in ESPERA_ID
        wait_n(510);
        enviar("4", 0, 1, 0);
        enviar("8", 0, 1, 0);
        enviar("#", 0, 1, 0);
        chk("p48_pos", int'({posicao1, posicao2, posicao3}), {3'd7, 3'd5, 3'd0});

        // '2','6', reset for one cycle during a high pulse, then '#'
        wait_n(601);
        enviar("2", 0, 0, 1);
        enviar("6", 0, 0, 2);
        chk("pre_rst_pwm1", int'(PMW1), 1);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_pwm", int'({PMW1, PMW2, PMW3}), 0);
        chk("mid_rst_estado", int'(db_estado), 0);
        reset = 1'b1;
        enviar("#", 0, 1, 0);
        chk("mid_rst_pos", int'({posicao1, posicao2, posicao3}), 0);

        // "13#" with '#' sampled on the counter=99 edge: new width only two periods on
        fork
            begin
                medir(1, h1, h2, h3);
                chk("wrap_p0_h1", h1, 10);
                medir(101, h1, h2, h3);
                chk("wrap_p1_h1", h1, 10);
            end
            begin
                wait_n(97);
                enviar("1", 0, 0, 1);
                enviar("3", 0, 0, 2);
                enviar("#", 1, 0, 0);
                chk("wrap_pos1", int'(posicao1), 3);
            end
        join
        medir(201, h1, h2, h3);
        chk("wrap_p2_h1", h1, 16); chk("wrap_p2_h2", h2, 10); chk("wrap_p2_h3", h3, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interpretador_servos.md
# interpretador_servos

Receive-side command interpreter and servo driver for the robot. It consumes the 7-bit ASCII characters and one-cycle ready pulses from the serial receiver and parses three-character servo commands. For each valid frame it updates one of three 3-bit position registers and drives three 50 Hz servo PWM outputs, which are the top level's `PMW1..3`. Malformed frames are discarded and flagged.

## Interface
Parameters:
- `PERIODO`, 1_000_000: PWM period in clock cycles (20 ms at 50 MHz).
- `LARGURA_MIN`, 50_000: high time for position 0 (1 ms).
- `PASSO`, 7_143: extra high cycles per position step. Position 7 gives 100_001.

Ports:
- `clock` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset (0 = reset).
- `dado_recebido` in 7: ASCII character from the serial receiver. Valid only when `pronto_recepcao`=1.
- `pronto_recepcao` in 1: one-cycle pulse indicating a new character.
- `PMW1`, `PMW2`, `PMW3` out 1: servo PWM outputs, registered.
- `posicao1`, `posicao2`, `posicao3` out 3: current commanded positions.
- `comando_valido` out 1: one-cycle pulse when a frame is applied.
- `erro_comando` out 1: one-cycle pulse when a frame is rejected.
- `db_estado` out 4: parser state for the hexa7seg display.

## Operation
- Frame format, in order: ID ∈ {'1','2','3'} (0x31–0x33), POS ∈ {'0'..'7'} (0x30–0x37), END = '#' (0x23).
- Characters arrive only on cycles with `pronto_recepcao`=1. `dado_recebido` is ignored on all other cycles.
- Parser states and `db_estado` codes: ESPERA_ID=0, ESPERA_POS=1, ESPERA_FIM=2.
- ESPERA_ID:
  - Valid ID: latch `id_pendente` and go to ESPERA_POS.
  - Any other character: stay, and pulse `erro_comando`.
- ESPERA_POS:
  - Valid POS: latch `pos_pendente` (the character minus 0x30) and go to ESPERA_FIM.
  - Otherwise: pulse `erro_comando` and go to ESPERA_ID.
- ESPERA_FIM:
  - '#': write `pos_pendente` into `posicao[id_pendente]`, pulse `comando_valido`, go to ESPERA_ID.
  - Otherwise: pulse `erro_comando`, go to ESPERA_ID. The rejected character is not reinterpreted as a new ID.
- Only the addressed position register changes. The other two hold.
- PWM generation:
  - A free-running counter runs 0..`PERIODO`-1 and wraps, shared by all three channels.
  - Each channel has a shadow width `largura_ativa` = `LARGURA_MIN` + `posicao`×`PASSO`.
  - The shadow is loaded only when the counter wraps to 0, so a period is never truncated or stretched mid-cycle.
  - `PMWn` is high while counter < `largura_ativa`.
- Width arithmetic: counter and widths are ceil(log2(`PERIODO`)) bits, unsigned. `LARGURA_MIN`+7×`PASSO` < `PERIODO` is a parameter-legality requirement. Violating it is out of scope.

## Timing
- Reset values, applied on the first rising edge with `reset`=0:
  - Parser in ESPERA_ID; `db_estado`=0.
  - `posicao1..3`=0; shadow widths = `LARGURA_MIN`.
  - Counter = 0; `PMW1..3`=0; `comando_valido`=`erro_comando`=0.
- First PWM period after reset:
  - Starts on the first edge with `reset`=1.
  - `PMWn` rises one cycle after counter=0, because the output is registered.
  - Each high pulse is exactly `largura_ativa` cycles; each period is exactly `PERIODO` cycles.
- Latency: if edge k samples '#' in ESPERA_FIM, then after edge k `posicaoN` holds the new value and `comando_valido`=1 for that one cycle.
- The new width appears on `PMWn` from the next counter wrap, so the worst-case delay is `PERIODO`+1 cycles.
- `erro_comando` follows the same rule: high for the single cycle after the sampling edge.
- Back-to-back characters (`pronto_recepcao` high on consecutive cycles) are all accepted. There is no busy state.
- Reset mid-frame discards the partial frame. Reset asserted during a pulse forces `PMWn`=0 on the next edge.
- A command arriving on the wrap cycle (counter = `PERIODO`-1) is picked up at the following wrap, not the current one.

## Structure
- Package `roberto_pkg` holds:
  - ASCII constants `ASC_ZERO`, `ASC_UM`, `ASC_TRES`, `ASC_SETE`, `ASC_FIM`.
  - The parser state typedef/encoding shared with `db_estado`.
- Sub-module `gerador_pwm`, instantiated 3×, takes the counter value, wrap strobe, 3-bit position and parameters. It outputs the registered PWM bit and holds the shadow register.
- The parser FSM and shared counter live in `interpretador_servos`.

## Test plan
All scenarios use a bench with `PERIODO`=100, `LARGURA_MIN`=10, `PASSO`=2.
- Reset release, no input: all `PMWn` high 10 cycles per 100-cycle period; `posicao`=0; `db_estado`=0.
- Send "25#", characters 1 cycle apart: `comando_valido` pulses once the cycle after '#'. `posicao2`=5 and the others stay 0. `PMW2` is 20 cycles high from the next period onward, and the current period is unchanged.
- Send "3X#" then "17#": one `erro_comando` pulse on 'X'. The following '#' in ESPERA_ID gives a second error pulse. Then `posicao1`=7 and `PMW1` is 24 cycles high.
- Send "48#": error on '4'. '8' and '#' each error in ESPERA_ID. No position changes.
- Send '2','6' then assert `reset`=0 for 1 cycle, then send "#": the frame is discarded, with one error pulse on '#' and `posicao2`=0.
- Deliver '#' of "13#" so `posicao1` changes on the counter=99 cycle: the new 16-cycle width starts one full period later. The in-progress and next-starting periods keep the old width, with no runt pulse.
